// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and the writeback request record for the regfile write-port arbiter.
package regfile_pkg;

    localparam int REGF_ADDR_W = 6;
    localparam int REGF_DATA_W = 32;
    localparam int REGF_CNT_W  = 16;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic                   valid;
        logic [REGF_ADDR_W-1:0] rd;
        logic [REGF_DATA_W-1:0] data;
    } wb_req_t;

    // True when a pending write to idx would be visible to a read of rs.
    function automatic logic raw_hit(input logic vld,
                                     input logic [REGF_ADDR_W-1:0] idx,
                                     input logic [REGF_ADDR_W-1:0] rs);
        return vld && (idx == rs);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback sources, decode read indices and regfile write port as seen by the arbiter.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGF_ADDR_W,
    parameter int DATA_W = REGF_DATA_W,
    parameter int CNT_W  = REGF_CNT_W
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              stall;
    logic              wrt;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] dataIn;
    logic [CNT_W-1:0]  coll_cnt;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output rs1, rs2,
        input  alu_ready, mem_ready, stall, wrt, rd, dataIn, coll_cnt
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  rs1, rs2,
        output alu_ready, mem_ready, stall, wrt, rd, dataIn, coll_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic r_ptr;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req == 2'b11)
                gnt = r_ptr ? 2'b10 : 2'b01;
            else
                gnt = req;
        end
    end

    // Pointer always moves away from whoever was just granted.
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= 1'b0;
        else if (gnt[REQ_ALU])
            r_ptr <= 1'b1;
        else if (gnt[REQ_MEM])
            r_ptr <= 1'b0;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single regfile write port, flags RAW stalls.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGF_ADDR_W,
    parameter int DATA_W = REGF_DATA_W,
    parameter int CNT_W  = REGF_CNT_W
)(
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  s_if
);
    wb_req_t                 w_req [NUM_REQ];
    logic [NUM_REQ-1:0]      w_req_vld;
    logic [NUM_REQ-1:0]      w_gnt;
    logic                    w_rs1_hit;
    logic                    w_rs2_hit;
    logic                    w_both;

    logic                    r_wrt;
    logic [ADDR_W-1:0]       r_rd;
    logic [DATA_W-1:0]       r_data;
    logic [CNT_W-1:0]        r_coll_cnt;

    always_comb begin
        w_req[REQ_ALU] = '{valid: s_if.alu_valid, rd: s_if.alu_rd, data: s_if.alu_data};
        w_req[REQ_MEM] = '{valid: s_if.mem_valid, rd: s_if.mem_rd, data: s_if.mem_data};
        for (int i = 0; i < NUM_REQ; i++)
            w_req_vld[i] = w_req[i].valid;
    end

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (w_req_vld),
        .gnt (w_gnt)
    );

    assign s_if.alu_ready = w_gnt[REQ_ALU];
    assign s_if.mem_ready = w_gnt[REQ_MEM];

    // rd/dataIn hold their last value when idle; only wrt qualifies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrt  <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else begin
            r_wrt <= |w_gnt;
            if (w_gnt[REQ_MEM]) begin
                r_rd   <= w_req[REQ_MEM].rd;
                r_data <= w_req[REQ_MEM].data;
            end else if (w_gnt[REQ_ALU]) begin
                r_rd   <= w_req[REQ_ALU].rd;
                r_data <= w_req[REQ_ALU].data;
            end
        end
    end

    // The regfile reads before it writes on an edge, so the registered write also hazards.
    always_comb begin
        w_rs1_hit = raw_hit(r_wrt, r_rd, s_if.rs1)
                  | raw_hit(w_req[REQ_ALU].valid, w_req[REQ_ALU].rd, s_if.rs1)
                  | raw_hit(w_req[REQ_MEM].valid, w_req[REQ_MEM].rd, s_if.rs1);
        w_rs2_hit = raw_hit(r_wrt, r_rd, s_if.rs2)
                  | raw_hit(w_req[REQ_ALU].valid, w_req[REQ_ALU].rd, s_if.rs2)
                  | raw_hit(w_req[REQ_MEM].valid, w_req[REQ_MEM].rd, s_if.rs2);
    end

    assign w_both = &w_req_vld;

    always_ff @(posedge clk) begin
        if (rst)
            r_coll_cnt <= '0;
        else if (w_both && (r_coll_cnt != {CNT_W{1'b1}}))
            r_coll_cnt <= r_coll_cnt + 1'b1;
    end

    assign s_if.stall    = w_rs1_hit | w_rs2_hit;
    assign s_if.wrt      = r_wrt;
    assign s_if.rd       = r_rd;
    assign s_if.dataIn   = r_data;
    assign s_if.coll_cnt = r_coll_cnt;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake, round-robin order, stall, collision counter.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    logic [REGF_DATA_W-1:0] rf_model [64];

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .s_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file that consumes the write port.
    always @(posedge clk)
        if (bus.wrt) rf_model[bus.rd] <= bus.dataIn;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.rs1 = '0; bus.rs2 = '0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 64; i++) rf_model[i] = '0;
        idle_inputs();

        // 1: reset with both sources requesting; readies must stay low
        rst = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_rd = 6'd1;
        bus.mem_valid = 1'b1; bus.mem_rd = 6'd2;
        tick();
        check("rst_alu_ready", bus.alu_ready, 0);
        check("rst_mem_ready", bus.mem_ready, 0);
        tick();
        check("rst_wrt", bus.wrt, 0);
        check("rst_rd", bus.rd, 0);
        check("rst_data", bus.dataIn, 0);
        check("rst_cnt", bus.coll_cnt, 0);
        rst = 1'b0;
        idle_inputs();
        #1;
        check("idle_stall", bus.stall, 0);
        tick();
        check("idle_wrt", bus.wrt, 0);
        check("idle_cnt", bus.coll_cnt, 0);

        // 2: single ALU writeback
        bus.alu_valid = 1'b1; bus.alu_rd = 6'd5; bus.alu_data = 32'h1234;
        #1;
        check("t2_alu_ready", bus.alu_ready, 1);
        check("t2_mem_ready", bus.mem_ready, 0);
        tick();
        bus.alu_valid = 1'b0;
        check("t2_wrt", bus.wrt, 1);
        check("t2_rd", bus.rd, 5);
        check("t2_data", bus.dataIn, 32'h1234);
        tick();
        check("t2_wrt_off", bus.wrt, 0);

        // pointer now favours MEM; pulse reset so test 3 starts from ALU
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 3: both valid, four back-to-back transfers
        bus.alu_valid = 1'b1; bus.alu_rd = 6'd2; bus.alu_data = 32'h22;
        bus.mem_valid = 1'b1; bus.mem_rd = 6'd8; bus.mem_data = 32'h88;
        #1;
        check("t3_g0_alu", bus.alu_ready, 1);
        check("t3_g0_mem", bus.mem_ready, 0);
        tick();
        bus.alu_rd = 6'd3; bus.alu_data = 32'h33;
        check("t3_w0_wrt", bus.wrt, 1);
        check("t3_w0_rd", bus.rd, 2);
        check("t3_w0_data", bus.dataIn, 32'h22);
        check("t3_cnt1", bus.coll_cnt, 1);
        check("t3_g1_mem", bus.mem_ready, 1);
        check("t3_g1_alu", bus.alu_ready, 0);
        tick();
        bus.mem_rd = 6'd4; bus.mem_data = 32'h44;
        check("t3_w1_wrt", bus.wrt, 1);
        check("t3_w1_rd", bus.rd, 8);
        check("t3_w1_data", bus.dataIn, 32'h88);
        check("t3_cnt2", bus.coll_cnt, 2);
        check("t3_g2_alu", bus.alu_ready, 1);
        tick();
        bus.alu_valid = 1'b0;
        #1;
        check("t3_w2_wrt", bus.wrt, 1);
        check("t3_w2_rd", bus.rd, 3);
        check("t3_w2_data", bus.dataIn, 32'h33);
        check("t3_cnt3", bus.coll_cnt, 3);
        check("t3_g3_mem", bus.mem_ready, 1);
        tick();
        bus.mem_valid = 1'b0;
        check("t3_w3_wrt", bus.wrt, 1);
        check("t3_w3_rd", bus.rd, 4);
        check("t3_w3_data", bus.dataIn, 32'h44);
        check("t3_cnt_hold", bus.coll_cnt, 3);
        tick();
        check("t3_wrt_off", bus.wrt, 0);
        check("t3_cnt_end", bus.coll_cnt, 3);

        // 4: same destination from both sources
        bus.alu_valid = 1'b1; bus.alu_rd = 6'd7; bus.alu_data = 32'hA;
        bus.mem_valid = 1'b1; bus.mem_rd = 6'd7; bus.mem_data = 32'hB;
        #1;
        check("t4_alu_first", bus.alu_ready, 1);
        tick();
        bus.alu_valid = 1'b0;
        check("t4_w0_data", bus.dataIn, 32'hA);
        check("t4_mem_next", bus.mem_ready, 1);
        tick();
        bus.mem_valid = 1'b0;
        check("t4_w1_rd", bus.rd, 7);
        check("t4_w1_data", bus.dataIn, 32'hB);
        tick();
        check("t4_r7", rf_model[7], 32'hB);
        check("t4_cnt", bus.coll_cnt, 4);

        // 5: RAW stall through pending request then registered write
        bus.rs1 = 6'd3; bus.rs2 = 6'd0;
        bus.mem_valid = 1'b1; bus.mem_rd = 6'd3; bus.mem_data = 32'h55;
        #1;
        check("t5_stall_req", bus.stall, 1);
        check("t5_mem_ready", bus.mem_ready, 1);
        tick();
        bus.mem_valid = 1'b0;
        #1;
        check("t5_stall_wrt", bus.stall, 1);
        tick();
        check("t5_stall_clear", bus.stall, 0);
        bus.rs1 = 6'd0; bus.rs2 = 6'd10;
        bus.alu_valid = 1'b1; bus.alu_rd = 6'd11;
        #1;
        check("t5_rs2_miss", bus.stall, 0);
        bus.alu_rd = 6'd10;
        #1;
        check("t5_rs2_hit", bus.stall, 1);
        bus.alu_valid = 1'b0;
        #1;

        // 6: reset right after a grant drops the write and re-arms the pointer
        bus.alu_valid = 1'b1; bus.alu_rd = 6'd1; bus.alu_data = 32'h77;
        tick();
        bus.alu_valid = 1'b0;
        rst = 1'b1;
        check("t6_wrt_pre", bus.wrt, 1);
        tick();
        check("t6_wrt_drop", bus.wrt, 0);
        check("t6_rd_clr", bus.rd, 0);
        rst = 1'b0;
        bus.alu_valid = 1'b1; bus.mem_valid = 1'b1;
        #1;
        check("t6_ptr_alu", bus.alu_ready, 1);
        check("t6_ptr_mem", bus.mem_ready, 0);
        for (int i = 0; i < 65534; i++) tick();
        check("t6_cnt_fffe", bus.coll_cnt, 16'hFFFE);
        tick();
        check("t6_cnt_ffff", bus.coll_cnt, 16'hFFFF);
        tick();
        tick();
        check("t6_cnt_sat", bus.coll_cnt, 16'hFFFF);
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
